// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: issues word reads to a one-cycle-latency SRAM and buffers
// responses in a small FIFO toward decode. Define IF_FETCH_BYPASS_EN for empty-FIFO bypass.
module if_fetch_unit #(
    parameter int unsigned             ADDR_SIZE  = 32,
    parameter int unsigned             WORD_SIZE  = 32,
    parameter int unsigned             BYTES      = 4,
    parameter logic [ADDR_SIZE-1:0]    RESET_PC   = '0,
    parameter int unsigned             FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 im_oe,
    output logic [BYTES-1:0]     im_web,
    output logic [ADDR_SIZE-1:0] im_addr,
    input  logic [WORD_SIZE-1:0] im_DI,
    output logic [WORD_SIZE-1:0] im_DO,
    input  logic                 redirect_valid,
    input  logic [ADDR_SIZE-1:0] redirect_pc,
    output logic                 id_valid,
    input  logic                 id_ready,
    output logic [WORD_SIZE-1:0] id_inst,
    output logic [ADDR_SIZE-1:0] id_pc
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
    logic                 inflight_q, inflight_d;
    logic [ADDR_SIZE-1:0] inflight_pc_q, inflight_pc_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;

    logic [ADDR_SIZE-1:0] pc_mem   [FIFO_DEPTH];
    logic [WORD_SIZE-1:0] inst_mem [FIFO_DEPTH];

    logic            bypass;
    logic            pop;
    logic            push;
    logic            issue;
    logic [CntW:0]   occ;

`ifdef IF_FETCH_BYPASS_EN
    assign bypass = inflight_q && (count_q == '0);
`else
    assign bypass = 1'b0;
`endif

    assign id_valid = !rst && !redirect_valid && ((count_q != '0) || bypass);
    assign pop      = id_valid && id_ready;
    // A bypassed response that decode takes this cycle never occupies a FIFO slot.
    assign push     = inflight_q && !redirect_valid && !(bypass && pop);

    // Slots already claimed after this cycle's pop, including the read still in flight.
    assign occ   = (CntW+1)'(count_q) + (CntW+1)'(inflight_q) - (CntW+1)'(pop);
    assign issue = !rst && !redirect_valid && (occ < (CntW+1)'(FIFO_DEPTH));

    assign im_oe   = issue;
    assign im_addr = rst ? RESET_PC : fetch_pc_q;
    assign im_web  = {BYTES{1'b1}};
    assign im_DO   = '0;

    always_comb begin
        id_inst = '0;
        id_pc   = '0;
        if (!rst) begin
            if (bypass) begin
                id_inst = im_DI;
                id_pc   = inflight_pc_q;
            end else begin
                id_inst = inst_mem[rd_ptr_q];
                id_pc   = pc_mem[rd_ptr_q];
            end
        end
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & ~ADDR_SIZE'(3);
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + ADDR_SIZE'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop && !bypass) rd_ptr_d = rd_ptr_q + PtrW'(1);
            count_d = count_q + CntW'(push) - CntW'(pop && !bypass);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
            inst_mem[wr_ptr_q] <= im_DI;
        end
    end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end that drives the core's instruction-memory port (`im_*`) and delivers a stream of fetched instructions to the decode stage over a valid/ready handshake. It holds the fetch PC, issues word reads to a synchronous SRAM with one-cycle read latency, and buffers returned words in a small FIFO so decode back-pressure never drops data. It also squashes everything in flight on a redirect (branch/jump/exception) from later stages.

## Interface
- `ADDR_SIZE`, 32, address width
- `WORD_SIZE`, 32, instruction width
- `BYTES`, 4, bytes per word; width of `im_web`
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 2, instruction buffer entries (power of two, ≥2)

Ports:
- `clk` in 1: single clock; all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `im_oe` out 1: read strobe to instruction memory
- `im_web` out BYTES: active-low byte write enables; constant all-ones
- `im_addr` out ADDR_SIZE: fetch address, word aligned
- `im_DI` in WORD_SIZE: read data, valid the cycle after `im_oe`
- `im_DO` out WORD_SIZE: write data; constant zero
- `redirect_valid` in 1: flush and restart at `redirect_pc`
- `redirect_pc` in ADDR_SIZE: new fetch address; bits [1:0] ignored
- `id_valid` out 1: FIFO head valid to decode
- `id_ready` in 1: decode accepts head
- `id_inst` out WORD_SIZE: instruction at FIFO head
- `id_pc` out ADDR_SIZE: PC of `id_inst`

## Operation
- State: `fetch_pc`, `inflight` (1 bit, read issued last cycle), `inflight_pc`, FIFO of {pc, inst} with `count`.
- Issue condition: `!rst && !redirect_valid && (count - pop + inflight) < FIFO_DEPTH`, where `pop = id_valid && id_ready`. Combinational path `id_ready -> im_oe` is intentional.
- On issue: `im_oe=1`, `im_addr=fetch_pc`; next cycle `fetch_pc += 4`, `inflight=1`, `inflight_pc=fetch_pc`. No issue: `im_oe=0`, `im_addr` still shows `fetch_pc`.
- Response: when `inflight=1`, `im_DI` and `inflight_pc` are pushed into the FIFO at the clock edge. The FIFO cannot overflow because issue reserved the slot.
- Pop: `id_valid = (count != 0) && !redirect_valid`; the head is retired on `id_valid && id_ready`. Push and pop may occur in the same cycle.
- Redirect (highest priority):
  - FIFO is cleared.
  - Any in-flight response is dropped (`inflight` cleared; data arriving next cycle ignored).
  - `fetch_pc <= {redirect_pc[ADDR_SIZE-1:2], 2'b00}`.
  - No issue and no pop happen in the redirect cycle. The first fetch from the new PC is issued the following cycle.
- Redirect asserted on consecutive cycles: the last one wins.
- PC arithmetic is modulo 2^ADDR_SIZE; `32'hFFFF_FFFC + 4 = 0`.
- `im_web` is always `{BYTES{1'b1}}` and `im_DO` is always 0; the unit never writes.

## Timing
- Reset (rst=1 at edge):
  - `fetch_pc=RESET_PC`, `inflight=0`, `count=0`, FIFO pointers 0.
  - While rst=1: `im_oe=0`, `id_valid=0`, `id_inst=0`, `id_pc=0`, `im_addr=RESET_PC`.
- First cycle with rst=0 issues `RESET_PC`.
- Reset asserted mid-operation discards FIFO and in-flight data exactly as a redirect to `RESET_PC`.
- Latency without bypass: issue cycle N, data on `im_DI` in N+1, `id_valid` in N+2.
- Throughput with `id_ready` held high: one instruction per cycle.
- Redirect in cycle R: `im_oe` low in R, first issue in R+1, `id_valid` from the new PC in R+3 (R+2 with bypass).
- With `id_ready=0`, at most FIFO_DEPTH instructions are buffered/in flight; `im_oe` stays low until space is available.

## Configuration
- `IF_FETCH_BYPASS_EN` defined: when the FIFO is empty and a response arrives, `id_valid=1` combinationally that cycle with `id_inst=im_DI` and `id_pc=inflight_pc`. If it is popped, it is not written to the FIFO. Latency is 1 cycle from issue.
- Undefined: every response passes through the FIFO; latency is 2 cycles; `id_*` outputs are driven only from registers.

## Test plan
- Reset release, RESET_PC=0, `id_ready=1`, memory returns `inst=addr^32'hA5A5_0000` -> `im_addr` 0,4,8,… on consecutive cycles; `id_valid` first high 2 cycles after first issue (1 with bypass); `id_pc` 0,4,8 with matching `id_inst`.
- `id_ready=0` for 6 cycles after streaming starts -> `im_oe` drops once 2 slots are used; no instruction lost or duplicated when ready returns.
- `redirect_valid` with `redirect_pc=32'h0000_0103` while FIFO holds 2 entries and one read is in flight -> `id_valid=0` that cycle; next issued `im_addr=32'h0000_0100`; the next `id_pc` seen is 0x100.
- Redirect coincident with a response arrival and with `id_ready=1` -> response dropped, no pop counted, stream resumes at the redirect target.
- `redirect_pc=32'hFFFF_FFF8` -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `rst` pulsed high for 1 cycle mid-stream -> `id_valid=0` during reset; fetch restarts at RESET_PC; `im_web` stays 4'hF and `im_DO` stays 0 throughout.
